// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intr_pkg
//  Description : Shared types and constants for the pipeline interrupt
//                sequencer (state encoding, default handler vector,
//                holdoff counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package intr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        TAKE    = 3'd2,
        HANDLER = 3'd3,
        RETURN  = 3'd4
    } intr_state_t;

    localparam logic [31:0] DEFAULT_HANDLER_VECTOR = 32'h0000_0180;
    localparam int          HOLDOFF_W              = 4;

endpackage
`default_nettype wire

// File: rtl/interrupt_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_sequencer_if
//  Description : Pipeline/COP0 <-> interrupt sequencer signal bundle.
//                slave  = the sequencer itself.
//                master = the surrounding pipeline and COP0.
//  Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_sequencer_if;
    logic        Enable;
    logic        InterruptRequest;
    logic        EretValid;
    logic [31:0] EPC;
    logic [31:0] ExecPC;
    logic        ExecValid;
    logic        ExecInDelaySlot;
    logic        MemStall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Flush;
    logic        InterruptHandled;
    logic [31:0] InterruptedPC;
    logic        InHandler;

    modport slave (
        input  Enable, InterruptRequest, EretValid, EPC, ExecPC,
               ExecValid, ExecInDelaySlot, MemStall,
        output Redirect, RedirectPC, Flush, InterruptHandled,
               InterruptedPC, InHandler
    );

    modport master (
        output Enable, InterruptRequest, EretValid, EPC, ExecPC,
               ExecValid, ExecInDelaySlot, MemStall,
        input  Redirect, RedirectPC, Flush, InterruptHandled,
               InterruptedPC, InHandler
    );
endinterface
`default_nettype wire

// File: rtl/intr_holdoff.sv
`default_nettype none
// ============================================================================
//  Module      : intr_holdoff
//  Description : Loadable down-counter for the post-ERET interrupt blackout.
//                Counts Enable-qualified cycles; flags zero and last count.
//  Revision    : 1.0 - initial release
// ============================================================================
module intr_holdoff
    import intr_pkg::*;
(
    input  wire logic                 Clock,
    input  wire logic                 Reset,
    input  wire logic                 enable,
    input  wire logic                 load,
    input  wire logic [HOLDOFF_W-1:0] load_value,
    output logic                      zero,
    output logic                      last
);

    logic [HOLDOFF_W-1:0] count;

    // Load on request, otherwise count down to zero on advancing cycles.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (enable) begin
            if (load) begin
                count <= load_value;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign zero = (count == '0);
    assign last = (count == HOLDOFF_W'(1));

endmodule
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_sequencer
//  Description : Takes COP0 interrupt requests at a precise point in the
//                execute stage, flushes and redirects fetch to the handler,
//                reports the interrupted PC to COP0, and sequences ERET.
//                Optional feature macro: INTR_HOLDOFF_EN (post-ERET blackout).
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_sequencer
    import intr_pkg::*;
#(
    parameter logic [31:0] HANDLER_VECTOR = DEFAULT_HANDLER_VECTOR,
    parameter int          HOLDOFF_CYCLES = 4
) (
    input  wire logic            Clock,
    input  wire logic            Reset,
    interrupt_sequencer_if.slave bus
);

    intr_state_t state;
    intr_state_t next_state;
    logic [31:0] captured_pc;
    logic        capture;
    logic        safe_point;
    logic        holdoff_clear;
    logic        active;

    assign safe_point = bus.ExecValid & ~bus.ExecInDelaySlot & ~bus.MemStall;
    // Strobes are suppressed in a reset cycle so an aborted TAKE never pulses.
    assign active     = bus.Enable & ~Reset;

`ifdef INTR_HOLDOFF_EN
    logic holdoff_zero;
    logic holdoff_last;

    intr_holdoff u_holdoff (
        .Clock      (Clock),
        .Reset      (Reset),
        .enable     (bus.Enable),
        .load       (state == RETURN),
        .load_value (HOLDOFF_W'(HOLDOFF_CYCLES)),
        .zero       (holdoff_zero),
        .last       (holdoff_last)
    );

    // The request is accepted on the final counted cycle, so WAIT lands on
    // the (HOLDOFF_CYCLES+1)-th advancing cycle after RETURN.
    assign holdoff_clear = holdoff_zero | holdoff_last;
`else
    // No blackout: IDLE accepts a request right after RETURN.
    assign holdoff_clear = 1'b1 | (HOLDOFF_CYCLES == 0);
`endif

    // State and captured-PC registers; both frozen while Enable is low.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            captured_pc <= 32'h0;
        end else begin
            state <= next_state;
            if (capture) begin
                captured_pc <= bus.ExecPC;
            end
        end
    end

    // Next-state logic; transitions only on advancing cycles.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        if (bus.Enable) begin
            unique case (state)
                IDLE: begin
                    if (bus.EretValid) begin
                        next_state = RETURN;
                    end else if (bus.InterruptRequest && holdoff_clear) begin
                        next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.InterruptRequest) begin
                        next_state = IDLE;
                    end else if (safe_point) begin
                        capture    = 1'b1;
                        next_state = TAKE;
                    end
                end
                TAKE:    next_state = HANDLER;
                HANDLER: if (bus.EretValid) next_state = RETURN;
                RETURN:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs: strobes qualified by Enable, redirect target by state.
    always_comb begin
        bus.Redirect         = 1'b0;
        bus.Flush            = 1'b0;
        bus.InterruptHandled = 1'b0;
        bus.RedirectPC       = 32'h0;
        bus.InHandler        = ~Reset & (state == HANDLER);
        bus.InterruptedPC    = captured_pc;
        if (active && state == TAKE) begin
            bus.Redirect         = 1'b1;
            bus.Flush            = 1'b1;
            bus.InterruptHandled = 1'b1;
            bus.RedirectPC       = HANDLER_VECTOR;
        end else if (active && state == RETURN) begin
            bus.Redirect   = 1'b1;
            bus.Flush      = 1'b1;
            bus.RedirectPC = bus.EPC;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_sequencer
//  Description : Self-checking bench for interrupt_sequencer. Each scenario
//                builds a per-cycle table of inputs and expected outputs;
//                expectations go into a scoreboard queue as the inputs are
//                driven and are popped and compared mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_sequencer;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    interrupt_sequencer_if bus ();

    interrupt_sequencer #(
        .HANDLER_VECTOR (32'h0000_0180),
        .HOLDOFF_CYCLES (4)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Observed/expected vector: {Redirect, Flush, InterruptHandled, InHandler,
    // RedirectPC, InterruptedPC}
    typedef logic [67:0] obs_t;

    typedef struct {
        logic        en, rst, irq, eret, valid, ds, stall;
        logic [31:0] epc, pc;
        obs_t        exp;
    } row_t;

    obs_t expq[$];
    int   checks = 0;
    int   passed = 0;

`ifdef INTR_HOLDOFF_EN
    localparam int TAKE_AFTER_RETURN = 6;
`else
    localparam int TAKE_AFTER_RETURN = 3;
`endif

    function automatic obs_t o(input logic r, f, h, i,
                               input logic [31:0] rpc, ipc);
        return {r, f, h, i, rpc, ipc};
    endfunction

    function automatic obs_t z(input logic [31:0] ipc);
        return {4'b0000, 32'h0, ipc};
    endfunction

    function automatic row_t rw(input logic en, rst, irq, eret, valid, ds, stall,
                                input logic [31:0] epc, pc, input obs_t exp);
        row_t r;
        r.en = en; r.rst = rst; r.irq = irq; r.eret = eret;
        r.valid = valid; r.ds = ds; r.stall = stall;
        r.epc = epc; r.pc = pc; r.exp = exp;
        return r;
    endfunction

    function automatic obs_t observe();
        return {bus.Redirect, bus.Flush, bus.InterruptHandled, bus.InHandler,
                bus.RedirectPC, bus.InterruptedPC};
    endfunction

    task automatic apply(input row_t r);
        @(posedge Clock);
        #1;
        Reset                = r.rst;
        bus.Enable           = r.en;
        bus.InterruptRequest = r.irq;
        bus.EretValid        = r.eret;
        bus.ExecValid        = r.valid;
        bus.ExecInDelaySlot  = r.ds;
        bus.MemStall         = r.stall;
        bus.EPC              = r.epc;
        bus.ExecPC           = r.pc;
    endtask

    // Leave HANDLER through ERET and idle long enough to clear any blackout.
    task automatic go_idle();
        apply(rw(1,0,0,1,0,0,0,32'h0,32'h0,'0));
        for (int k = 0; k < 8; k++) apply(rw(1,0,0,0,0,0,0,32'h0,32'h0,'0));
    endtask

    task automatic test_reset();
        row_t rows[$];
        obs_t e, ob;
        rows.push_back(rw(1,1,0,0,0,0,0,32'h0,32'h0, z(32'h0)));
        rows.push_back(rw(1,1,0,0,0,0,0,32'h0,32'h0, z(32'h0)));
        rows.push_back(rw(1,0,0,0,0,0,0,32'h0,32'h0, z(32'h0)));
        foreach (rows[i]) begin
            apply(rows[i]);
            expq.push_back(rows[i].exp);
            @(negedge Clock);
            e = expq.pop_front(); ob = observe(); checks++;
            if (ob !== e) $display("FAIL reset[%0d]: got %h want %h", i, ob, e);
            else passed++;
        end
    endtask

    task automatic test_basic_take();
        row_t rows[$];
        obs_t e, ob;
        rows.push_back(rw(1,0,1,0,1,0,0,32'h0,32'h40,  z(32'h0)));
        rows.push_back(rw(1,0,1,0,1,0,0,32'h0,32'h40,  z(32'h0)));
        rows.push_back(rw(1,0,0,0,1,0,0,32'h0,32'h44,  o(1,1,1,0,32'h180,32'h40)));
        rows.push_back(rw(1,0,0,0,1,0,0,32'h0,32'h180, o(0,0,0,1,32'h0,32'h40)));
        foreach (rows[i]) begin
            apply(rows[i]);
            expq.push_back(rows[i].exp);
            @(negedge Clock);
            e = expq.pop_front(); ob = observe(); checks++;
            if (ob !== e) $display("FAIL basic_take[%0d]: got %h want %h", i, ob, e);
            else passed++;
        end
    endtask

    // ERET from HANDLER, then a request held high to measure re-entry.
    task automatic test_return_holdoff();
        row_t rows[$];
        obs_t e, ob;
        rows.push_back(rw(1,0,0,1,1,0,0,32'h40,32'h190, o(0,0,0,1,32'h0,32'h40)));
        rows.push_back(rw(1,0,0,0,0,0,0,32'h40,32'h0,   o(1,1,0,0,32'h40,32'h40)));
        for (int k = 1; k < TAKE_AFTER_RETURN; k++)
            rows.push_back(rw(1,0,1,0,1,0,0,32'h0,32'h100, z(32'h40)));
        rows.push_back(rw(1,0,1,0,1,0,0,32'h0,32'h100, o(1,1,1,0,32'h180,32'h100)));
        rows.push_back(rw(1,0,0,0,0,0,0,32'h0,32'h0,   o(0,0,0,1,32'h0,32'h100)));
        foreach (rows[i]) begin
            apply(rows[i]);
            expq.push_back(rows[i].exp);
            @(negedge Clock);
            e = expq.pop_front(); ob = observe(); checks++;
            if (ob !== e) $display("FAIL return_holdoff[%0d]: got %h want %h", i, ob, e);
            else passed++;
        end
    endtask

    task automatic test_delay_slot_stall();
        row_t rows[$];
        obs_t e, ob;
        rows.push_back(rw(1,0,1,0,1,1,0,32'h0,32'h7c, z(32'h100)));
        for (int k = 0; k < 3; k++)
            rows.push_back(rw(1,0,1,0,1,1,0,32'h0,32'h80, z(32'h100)));
        rows.push_back(rw(1,0,1,0,1,0,1,32'h0,32'h84, z(32'h100)));
        rows.push_back(rw(1,0,1,0,1,0,0,32'h0,32'h88, z(32'h100)));
        rows.push_back(rw(1,0,1,0,1,0,0,32'h0,32'h8c, o(1,1,1,0,32'h180,32'h88)));
        rows.push_back(rw(1,0,0,0,0,0,0,32'h0,32'h0,  o(0,0,0,1,32'h0,32'h88)));
        foreach (rows[i]) begin
            apply(rows[i]);
            expq.push_back(rows[i].exp);
            @(negedge Clock);
            e = expq.pop_front(); ob = observe(); checks++;
            if (ob !== e) $display("FAIL delay_slot_stall[%0d]: got %h want %h", i, ob, e);
            else passed++;
        end
    endtask

    task automatic test_enable_freeze();
        row_t rows[$];
        obs_t e, ob;
        rows.push_back(rw(1,0,1,0,1,0,0,32'h0,32'h200, z(32'h88)));
        rows.push_back(rw(1,0,1,0,1,0,0,32'h0,32'h200, z(32'h88)));
        for (int k = 0; k < 3; k++)
            rows.push_back(rw(0,0,1,0,1,0,0,32'h0,32'h204, z(32'h200)));
        rows.push_back(rw(1,0,0,0,1,0,0,32'h0,32'h204, o(1,1,1,0,32'h180,32'h200)));
        rows.push_back(rw(1,0,0,0,0,0,0,32'h0,32'h0,   o(0,0,0,1,32'h0,32'h200)));
        foreach (rows[i]) begin
            apply(rows[i]);
            expq.push_back(rows[i].exp);
            @(negedge Clock);
            e = expq.pop_front(); ob = observe(); checks++;
            if (ob !== e) $display("FAIL enable_freeze[%0d]: got %h want %h", i, ob, e);
            else passed++;
        end
    endtask

    task automatic test_abort_priority();
        row_t rows[$];
        obs_t e, ob;
        rows.push_back(rw(1,0,1,0,0,0,0,32'h0,32'h0,     z(32'h200)));
        rows.push_back(rw(1,0,0,0,1,0,0,32'h0,32'h300,   z(32'h200)));
        rows.push_back(rw(1,0,0,0,1,0,0,32'h0,32'h300,   z(32'h200)));
        rows.push_back(rw(1,0,1,1,1,0,0,32'h500,32'h300, z(32'h200)));
        rows.push_back(rw(1,0,0,0,0,0,0,32'h500,32'h0,   o(1,1,0,0,32'h500,32'h200)));
        for (int k = 0; k < 6; k++)
            rows.push_back(rw(1,0,0,0,0,0,0,32'h0,32'h0, z(32'h200)));
        foreach (rows[i]) begin
            apply(rows[i]);
            expq.push_back(rows[i].exp);
            @(negedge Clock);
            e = expq.pop_front(); ob = observe(); checks++;
            if (ob !== e) $display("FAIL abort_priority[%0d]: got %h want %h", i, ob, e);
            else passed++;
        end
    endtask

    task automatic test_reset_in_take();
        row_t rows[$];
        obs_t e, ob;
        rows.push_back(rw(1,0,1,0,1,0,0,32'h0,32'h400, z(32'h200)));
        rows.push_back(rw(1,0,1,0,1,0,0,32'h0,32'h400, z(32'h200)));
        rows.push_back(rw(1,1,1,0,1,0,0,32'h0,32'h400, z(32'h400)));
        rows.push_back(rw(1,0,0,0,0,0,0,32'h0,32'h0,   z(32'h0)));
        rows.push_back(rw(1,0,0,0,0,0,0,32'h0,32'h0,   z(32'h0)));
        foreach (rows[i]) begin
            apply(rows[i]);
            expq.push_back(rows[i].exp);
            @(negedge Clock);
            e = expq.pop_front(); ob = observe(); checks++;
            if (ob !== e) $display("FAIL reset_in_take[%0d]: got %h want %h", i, ob, e);
            else passed++;
        end
    endtask

    initial begin
        bus.Enable           = 1'b1;
        bus.InterruptRequest = 1'b0;
        bus.EretValid        = 1'b0;
        bus.EPC              = 32'h0;
        bus.ExecPC           = 32'h0;
        bus.ExecValid        = 1'b0;
        bus.ExecInDelaySlot  = 1'b0;
        bus.MemStall         = 1'b0;

        test_reset();
        test_basic_take();
        test_return_holdoff();
        go_idle();
        test_delay_slot_stall();
        go_idle();
        test_enable_freeze();
        go_idle();
        test_abort_priority();
        test_reset_in_take();

        if (expq.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", expq.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
